// File: rtl/axi_wr_pkg.sv
// Shared types and helpers for the AXI write-address generator.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WAIT  = 2'd1,
    WR_ISSUE = 2'd2
  } wr_state_e;

  localparam int unsigned MIN_NUM_BUFS = 2;
  localparam int unsigned MAX_NUM_BUFS = 8;

  // Bytes in one line-buffer chunk; width is a whole number of bytes.
  function automatic int unsigned chunk_bytes(input int unsigned depth,
                                              input int unsigned width);
    return (depth * width) / 8;
  endfunction

endpackage

// File: rtl/axi_wr_pending_tracker.sv
// Per-buffer pending flags: set by full pulses, cleared by command accept,
// with sticky overflow when a pulse lands on a buffer that is still pending.
module axi_wr_pending_tracker
  import axi_wr_pkg::*;
#(
  parameter int unsigned NUM_BUFS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic [NUM_BUFS-1:0] set_i,
  input  logic [NUM_BUFS-1:0] clr_i,
  output logic [NUM_BUFS-1:0] pending_o,
  output logic                overflow_o
);

  logic [NUM_BUFS-1:0] pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic                ovf_hit;

  // A set on the buffer being accepted in the same cycle is a legal refill,
  // so only pending flags that are not being cleared can overflow.
  assign ovf_hit = |(set_i & pending_q & ~clr_i);

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else begin
      pending_d  = (pending_q & ~clr_i) | set_i;
      overflow_d = overflow_q | ovf_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/axi_write_addr_gen.sv
// Turns line-buffer full pulses into round-robin AXI write commands that walk
// a ring of contiguous frame stores.
module axi_write_addr_gen
  import axi_wr_pkg::*;
#(
  parameter int unsigned AXIS_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 24,
  parameter int unsigned BUFFER_DEPTH    = 1024,
  parameter int unsigned NUM_BUFS        = 2,
  parameter int unsigned CHUNK_CNT_W     = 16,
  parameter int unsigned FRAME_CNT_W     = 3,
  localparam int unsigned BUF_ID_W       = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [AXIS_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [CHUNK_CNT_W-1:0]     cfg_num_chunks,
  input  logic [FRAME_CNT_W-1:0]     cfg_num_frames,
  input  logic [NUM_BUFS-1:0]        buf_full,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [AXIS_ADDR_WIDTH-1:0] cmd_addr,
  output logic [BUF_ID_W-1:0]        cmd_buf_id,
  output logic [AXIS_ADDR_WIDTH-1:0] cmd_bytes,
  output logic                       frame_done,
  output logic [FRAME_CNT_W-1:0]     frame_idx,
  output logic                       overflow,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'(WR_IDLE);
  localparam logic [1:0] S_WAIT  = 2'(WR_WAIT);
  localparam logic [1:0] S_ISSUE = 2'(WR_ISSUE);

  localparam logic [AXIS_ADDR_WIDTH-1:0] CHUNK_BYTES =
    AXIS_ADDR_WIDTH'(chunk_bytes(BUFFER_DEPTH, DATA_WIDTH));
  localparam logic [BUF_ID_W-1:0] LAST_BUF = BUF_ID_W'(NUM_BUFS - 1);

  logic [1:0]                 state_q, state_d;
  logic [AXIS_ADDR_WIDTH-1:0] base_q, base_d;
  logic [CHUNK_CNT_W-1:0]     num_chunks_q, num_chunks_d;
  logic [FRAME_CNT_W-1:0]     num_frames_q, num_frames_d;
  logic [AXIS_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [CHUNK_CNT_W-1:0]     chunk_cnt_q, chunk_cnt_d;
  logic [FRAME_CNT_W-1:0]     frame_idx_q, frame_idx_d;
  logic [BUF_ID_W-1:0]        next_buf_q, next_buf_d;
  logic [AXIS_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [BUF_ID_W-1:0]        cmd_buf_id_q, cmd_buf_id_d;
  logic                       frame_done_q, frame_done_d;

  logic [NUM_BUFS-1:0] pending;
  logic [NUM_BUFS-1:0] pend_set;
  logic [NUM_BUFS-1:0] pend_clr;
  logic                pend_clear_all;
  logic                accept;
  logic                last_chunk;
  logic                last_frame;

  // Valid/ready: cmd_valid is a pure function of state, so it never looks at
  // cmd_ready; while valid, payload registers only change on accept.
  assign cmd_valid = (state_q == S_ISSUE);
  assign accept    = cmd_valid & cmd_ready;

  assign last_chunk = (chunk_cnt_q == num_chunks_q - CHUNK_CNT_W'(1));
  assign last_frame = (frame_idx_q == num_frames_q - FRAME_CNT_W'(1));

  assign pend_set = buf_full & {NUM_BUFS{state_q != S_IDLE}};
  assign pend_clr = accept ? (NUM_BUFS'(1) << next_buf_q) : '0;

  axi_wr_pending_tracker #(
    .NUM_BUFS (NUM_BUFS)
  ) u_pending (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (pend_clear_all),
    .set_i      (pend_set),
    .clr_i      (pend_clr),
    .pending_o  (pending),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    num_chunks_d   = num_chunks_q;
    num_frames_d   = num_frames_q;
    cur_addr_d     = cur_addr_q;
    chunk_cnt_d    = chunk_cnt_q;
    frame_idx_d    = frame_idx_q;
    next_buf_d     = next_buf_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_buf_id_d   = cmd_buf_id_q;
    frame_done_d   = 1'b0;
    pend_clear_all = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d        = S_WAIT;
          base_d         = cfg_base_addr;
          num_chunks_d   = cfg_num_chunks;
          num_frames_d   = cfg_num_frames;
          cur_addr_d     = cfg_base_addr;
          chunk_cnt_d    = '0;
          frame_idx_d    = '0;
          next_buf_d     = '0;
          pend_clear_all = 1'b1;
        end
      end

      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (pending[next_buf_q]) begin
          state_d      = S_ISSUE;
          cmd_addr_d   = cur_addr_q;
          cmd_buf_id_d = next_buf_q;
        end
      end

      S_ISSUE: begin
        if (accept) begin
          next_buf_d = (next_buf_q == LAST_BUF) ? '0 : next_buf_q + BUF_ID_W'(1);
          if (last_chunk) begin
            chunk_cnt_d  = '0;
            frame_done_d = 1'b1;
            if (last_frame) begin
              frame_idx_d = '0;
              cur_addr_d  = base_q;
            end else begin
              frame_idx_d = frame_idx_q + FRAME_CNT_W'(1);
              cur_addr_d  = cur_addr_q + CHUNK_BYTES;
            end
          end else begin
            chunk_cnt_d = chunk_cnt_q + CHUNK_CNT_W'(1);
            cur_addr_d  = cur_addr_q + CHUNK_BYTES;
          end

          // The buffer after the one just accepted is never the one being
          // cleared, so the registered flag alone decides back-to-back issue.
          if (!enable) begin
            state_d = S_IDLE;
          end else if (pending[next_buf_d]) begin
            cmd_addr_d   = cur_addr_d;
            cmd_buf_id_d = next_buf_d;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      num_chunks_q <= '0;
      num_frames_q <= '0;
      cur_addr_q   <= '0;
      chunk_cnt_q  <= '0;
      frame_idx_q  <= '0;
      next_buf_q   <= '0;
      cmd_addr_q   <= '0;
      cmd_buf_id_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      num_chunks_q <= num_chunks_d;
      num_frames_q <= num_frames_d;
      cur_addr_q   <= cur_addr_d;
      chunk_cnt_q  <= chunk_cnt_d;
      frame_idx_q  <= frame_idx_d;
      next_buf_q   <= next_buf_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_buf_id_q <= cmd_buf_id_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cmd_addr   = cmd_addr_q;
  assign cmd_buf_id = cmd_buf_id_q;
  assign cmd_bytes  = CHUNK_BYTES;
  assign frame_done = frame_done_q;
  assign frame_idx  = frame_idx_q;
  assign busy       = (|pending) | cmd_valid;
  assign dbg_state  = state_q;

endmodule

// File: doc/axi_write_addr_gen.md
# axi_write_addr_gen

Parametrised write-address generator between the video line buffers and the AXI write master. Each buffer-full pulse from up to NUM_BUFS ping-pong/round-robin buffers is latched as a pending chunk. Pending chunks are issued in strict buffer order as valid/ready write commands carrying address, buffer id and byte count. Addresses walk a ring of cfg_num_frames contiguous frame stores starting at cfg_base_addr, with wrap-around, per-frame completion pulses and overflow detection.

## Interface
- AXIS_ADDR_WIDTH, 32: write address width.
- DATA_WIDTH, 24: pixel width in bits; must be a multiple of 8.
- BUFFER_DEPTH, 1024: pixels per buffer (chunk).
- NUM_BUFS, 2: number of source buffers, 2..8.
- CHUNK_CNT_W, 16: width of cfg_num_chunks.
- FRAME_CNT_W, 3: width of cfg_num_frames and frame_idx.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run enable; 0→1 edge latches config.
- cfg_base_addr  in  AXIS_ADDR_WIDTH  first byte of frame store 0.
- cfg_num_chunks  in  CHUNK_CNT_W  chunks per frame, ≥1.
- cfg_num_frames  in  FRAME_CNT_W  frame stores in ring, ≥1.
- buf_full  in  NUM_BUFS  single-cycle full pulse per buffer.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  AXI master accepts command.
- cmd_addr  out  AXIS_ADDR_WIDTH  chunk start address.
- cmd_buf_id  out  clog2(NUM_BUFS)  buffer to drain.
- cmd_bytes  out  AXIS_ADDR_WIDTH  CHUNK_BYTES constant.
- frame_done  out  1  one-cycle pulse on last chunk of a frame accepted.
- frame_idx  out  FRAME_CNT_W  frame store currently being written.
- overflow  out  1  sticky: full pulse on an already-pending buffer.
- busy  out  1  any pending chunk or cmd_valid high.

## Operation
- CHUNK_BYTES = BUFFER_DEPTH*DATA_WIDTH/8. Address arithmetic is modulo 2^AXIS_ADDR_WIDTH. There are no multipliers: cur_addr advances by CHUNK_BYTES per accept.
- States: IDLE (enable=0), WAIT (pending[next_buf]=0), ISSUE (cmd_valid=1).
- IDLE→WAIT on enable rising:
  - latch cfg_*;
  - cur_addr=cfg_base_addr; chunk_cnt=0; frame_idx=0; next_buf=0;
  - clear pending and overflow.
- buf_full[i] sets pending[i] in every state except IDLE. Pulses in IDLE are ignored.
- WAIT→ISSUE when pending[next_buf]=1. The payload is registered: cmd_addr=cur_addr, cmd_buf_id=next_buf.
- ISSUE, accept = cmd_valid & cmd_ready:
  - clear pending[next_buf];
  - next_buf = (next_buf+1) mod NUM_BUFS;
  - cur_addr += CHUNK_BYTES; chunk_cnt++.
- End of frame (chunk_cnt = cfg_num_chunks-1 on accept): chunk_cnt=0, frame_done pulses.
  - Not the last frame store: frame_idx++.
  - Last frame store: frame_idx=0, cur_addr=cfg_base_addr.
- After accept: ISSUE again if the new next_buf is pending, else WAIT.
- Out-of-order pending buffers wait; strict round-robin order is preserved.
- Same-cycle accept and buf_full on that same buffer: the set wins, pending stays 1, no overflow.
- buf_full[i] while pending[i]=1 and not being accepted: overflow=1 (sticky), pulse dropped.
- enable falling mid-ISSUE: the current command completes (valid held until accept), then → IDLE. enable low in WAIT → IDLE next cycle.
- rst at any time: all state and outputs to reset values next cycle; an in-flight command is abandoned.

## Timing
- Reset values: cmd_valid=0, cmd_addr=0, cmd_buf_id=0, cmd_bytes=CHUNK_BYTES, frame_done=0, frame_idx=0, overflow=0, busy=0.
- Valid/ready: once asserted, cmd_valid and payload hold stable until accept. cmd_valid never depends combinationally on cmd_ready.
- Latency: buf_full at cycle N → pending at N+1 → cmd_valid at N+2 (if next_buf matches, state WAIT).
- Back-to-back: with both buffers pending, commands are accepted on consecutive cycles (1/cycle).
- frame_done and frame_idx update in the cycle after the accepting edge.

## Structure
- Package axi_wr_pkg: state enum (IDLE/WAIT/ISSUE), function chunk_bytes(depth,width), NUM_BUFS limit constant.
- Sub-module axi_wr_pending_tracker: per-buffer set/clear flags with overflow detection. Top holds the FSM and address/frame counters.

## Test plan
- Reset/defaults: rst high 2 cycles, enable=1 base 0x1000_0000, chunks=4, frames=2, buf_full[0] → cmd_addr 0x1000_0000, cmd_bytes 3072, buf_id 0 at N+2.
- Ping-pong walk: alternate full a/b, ready=1, 8 chunks:
  - addresses 0x1000_0000 + k*0xC00;
  - frame_done after chunks 4 and 8;
  - ninth chunk wraps to 0x1000_0000, frame_idx 0.
- Backpressure: ready=0 for 5 cycles → addr/buf_id stable, then accepted once; simultaneous full on buf 1 issues the next cycle.
- Order: buf_full[1] before [0] with next_buf=0 → buf 0 issued first, then 1.
- Overflow: two pulses on buf 0 with ready=0 → overflow=1 sticky; pulse on same cycle as accept → overflow stays 0.
- Mid-op: enable drop during ISSUE → completes on ready then idles; rst mid-ISSUE → cmd_valid=0 next cycle, counters zero.
